multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Main control FSM of the multicycle MIPS datapath; sits directly upstream of the ALU-control decoder.
//  Sequences each instruction through fetch/decode/execute/memory/writeback from the opcode.
//  Drives the datapath enables, mux selects and the 2-bit alu_op consumed by the ALU-control stage.
//  Also stalls on memory and counts retired instructions.
// PARAMETERS
//  STATE_W  4   width of state register (must hold 12 states)
//  CNT_W    32  width of retired-instruction counter (wraps modulo 2^CNT_W)
// PORTS
//  clock        in   1      single system clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  opcode       in   6      instr[31:26] from instruction register, sampled in DECODE
//  mem_ready    in   1      memory handshake: access completes in a cycle where mem_ready=1
//  pc_write     out  1      unconditional PC load
//  pc_write_cond out 1      PC load if ALU zero (branch)
//  i_or_d       out  1      memory address select: 0=PC, 1=ALUOut
//  mem_read     out  1      memory read request
//  mem_write    out  1      memory write request
//  mem_to_reg   out  1      writeback select: 0=ALUOut, 1=MDR
//  ir_write     out  1      instruction register load
//  pc_source    out  2      00=ALU, 01=ALUOut, 10=jump target
//  alu_op       out  2      00=add, 01=sub, 10=use funct (to ALU-control stage)
//  alu_src_a    out  1      0=PC, 1=rs
//  alu_src_b    out  2      00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  reg_write    out  1      register file write enable
//  reg_dst      out  1      dest select: 0=rt, 1=rd
//  illegal_op   out  1      one-cycle pulse: unsupported opcode seen in DECODE
//  instr_count  out  CNT_W  retired instructions
// BEHAVIOUR
//  - Reset low: state<=FETCH, instr_count<=0; all control outputs and illegal_op forced 0 while reset low.
//  - Moore outputs decoded from state register; exception: in FETCH, pc_write/ir_write = mem_ready.
//  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
//    Hold while mem_ready=0; on mem_ready=1 -> DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
//    Next state by opcode: 0x23/0x2B->MEMADR, 0x00->EXEC, 0x04->BRANCH, 0x02->JUMP, others->FETCH + illegal_op=1.
//  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; LW->MEMRD, SW->MEMWR.
//  - MEMRD: mem_read=1, i_or_d=1; hold until mem_ready=1 -> MEMWB.
//  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
//  - MEMWR: mem_write=1, i_or_d=1; hold until mem_ready=1 -> FETCH.
//  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
//  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
//  - JUMP: pc_write=1, pc_source=10 -> FETCH.
//  - instr_count +1 on each transition into FETCH from MEMWB, MEMWR (on mem_ready), ALUWB, BRANCH, JUMP, ADDIWB.
//    Not incremented for illegal opcodes; wraps to 0 past all-ones.
//  - Unused/unreachable state encodings -> FETCH next cycle, outputs 0.
//  - Reset asserted mid-instruction aborts immediately; no partial writes after release.
//  - CPI (mem_ready tied 1): R=4, LW=5, SW=4, BEQ=3, J=3.
// CONFIGURATION
//  ADDI_EN defined: opcode 0x08 DECODE->ADDIEX->ADDIWB->FETCH.
//    ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0.
//  ADDI_EN undefined: opcode 0x08 is illegal (illegal_op pulse, back to FETCH); ADDI states not built.
// STRUCTURE
//  Shared include mips_defs.vh: state encodings; opcode constants (R=0x00, J=0x02, BEQ=0x04, ADDI=0x08, LW=0x23, SW=0x2B);
//    alu_op codes (ADD=2'b00, SUB=2'b01, FUNCT=2'b10); alu_src_b and pc_source codes.
//  One sub-module control_decode: combinational state -> control-word decoder.
//  Top holds state register, next-state logic, instr_count.
// TESTING
//  1. Reset low mid-EXEC, release; mem_ready=1 -> outputs 0 during reset, FETCH first, instr_count=0.
//  2. R-type opcode 0x00, mem_ready=1 -> FETCH,DECODE,EXEC(alu_op=10),ALUWB(reg_dst=1); count 0->1 in 4 cycles.
//  3. LW 0x23, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_read=1, i_or_d=1; MEMWB mem_to_reg=1.
//  4. BEQ 0x04 then J 0x02 -> BRANCH alu_op=01, pc_write_cond=1, pc_source=01; JUMP pc_write=1, pc_source=10; count +2.
//  5. Opcode 0x3F in DECODE -> illegal_op high one cycle, next state FETCH, count unchanged.
//  6. Opcode 0x08: with ADDI_EN -> 4-cycle ADDI, reg_write in ADDIWB; without -> illegal_op pulse.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state encodings,
// opcode constants, datapath select codes and the packed control word.
package multicycle_control_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_R    = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J    = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_LW   = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW   = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational state -> control-word decoder for the multicycle control FSM.
// ADDI_EN adds decoding of the ADDI execute/writeback states.
module multicycle_control_decode
    import multicycle_control_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // PC increment and IR load commit only on the cycle the fetch completes
                ctrl.pc_write  = mem_ready;
                ctrl.ir_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMMSH2;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ST_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef ADDI_EN
            ST_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath with memory stalls and a
// retired-instruction counter. Define ADDI_EN to build the ADDI states.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             ir_write,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t state;
    state_t state_next;
    logic   is_store;
    logic   is_store_next;
    logic   illegal_c;
    logic   retire_c;
    ctrl_t  ctrl_c;
    ctrl_t  ctrl;

    // State register; the load/store choice is captured while the opcode is decoded
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_FETCH;
            is_store <= 1'b0;
        end else begin
            state    <= state_next;
            is_store <= is_store_next;
        end
    end

    always_comb begin
        state_next    = ST_FETCH;
        is_store_next = is_store;
        illegal_c     = 1'b0;
        retire_c      = 1'b0;
        case (state)
            ST_FETCH:  state_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                is_store_next = (opcode == OP_SW);
                case (opcode)
                    OP_LW, OP_SW: state_next = ST_MEMADR;
                    OP_R:         state_next = ST_EXEC;
                    OP_BEQ:       state_next = ST_BRANCH;
                    OP_J:         state_next = ST_JUMP;
`ifdef ADDI_EN
                    OP_ADDI:      state_next = ST_ADDIEX;
`endif
                    default: begin
                        state_next = ST_FETCH;
                        illegal_c  = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: state_next = is_store ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  state_next = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB: begin
                state_next = ST_FETCH;
                retire_c   = 1'b1;
            end
            ST_MEMWR: begin
                state_next = mem_ready ? ST_FETCH : ST_MEMWR;
                retire_c   = mem_ready;
            end
            ST_EXEC:   state_next = ST_ALUWB;
            ST_ALUWB, ST_BRANCH, ST_JUMP: begin
                state_next = ST_FETCH;
                retire_c   = 1'b1;
            end
`ifdef ADDI_EN
            ST_ADDIEX: state_next = ST_ADDIWB;
            ST_ADDIWB: begin
                state_next = ST_FETCH;
                retire_c   = 1'b1;
            end
`endif
            default:   state_next = ST_FETCH;
        endcase
    end

    // Retired-instruction counter, wraps modulo 2^CNT_W
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_count <= '0;
        end else if (retire_c) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    multicycle_control_decode u_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_c)
    );

    // Every control output is held low while reset is asserted
    assign ctrl          = reset ? ctrl_c : '0;
    assign illegal_op    = reset & illegal_c;

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign ir_write      = ctrl.ir_write;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;

endmodule
